// File: rtl/pipe_rr_arbiter_if.sv
// Handshake bundle between NREQ requesters, the round-robin arbiter and the
// downstream pipeline stage. The arbiter uses the slave view; the
// requester/pipeline side uses the master view.
interface pipe_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_allowin;
  logic                  out_allow;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [ID_W-1:0]       out_id;

  modport slave (
    input  req_valid, req_data, req_last, out_allow,
    output req_allowin, out_valid, out_data, out_id
  );

  modport master (
    output req_valid, req_data, req_last, out_allow,
    input  req_allowin, out_valid, out_data, out_id
  );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding one registered pipeline stage.
// Grants at most one requester per cycle; the winning beat and its source
// id are captured into the output register when the stage can accept.
// Optional burst lock enabled by defining ARB_LOCK_EN: a granted beat with
// req_last=0 pins arbitration to that requester until its last beat.
module pipe_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_rr_arbiter_if.slave    bus
);

  localparam int unsigned N = NREQ;

  logic             stage_allowin;
  logic             has_winner;
  logic             grant;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  last_grant;
  logic [WIDTH-1:0] sel_data;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [ID_W-1:0]  out_id_q;

`ifdef ARB_LOCK_EN
  logic             sel_last;
  logic             locked;
  logic [ID_W-1:0]  lock_id;
`else
  logic             unused_last;
  assign unused_last = ^bus.req_last;
`endif

  assign stage_allowin = !out_valid_q || bus.out_allow;
  assign grant         = rst_n && has_winner && stage_allowin;

  // Winner selection: smallest rotated distance from last_grant+1 wins,
  // which yields the order last_grant+1, ..., last_grant.
  always_comb begin : pick
    int unsigned best_d;
    int unsigned d;
    has_winner = 1'b0;
    winner     = last_grant;
    best_d     = N;
    d          = 0;
    for (int unsigned i = 0; i < N; i++) begin
      d = (i + 2 * N - 1 - 32'(last_grant)) % N;
      if (bus.req_valid[i] && d < best_d) begin
        best_d     = d;
        winner     = ID_W'(i);
        has_winner = 1'b1;
      end
    end
`ifdef ARB_LOCK_EN
    if (locked) begin
      winner     = lock_id;
      has_winner = bus.req_valid[lock_id];
    end
`endif
  end

  // Data (and last flag) mux for the selected requester, plus one-hot grant.
  always_comb begin
    sel_data        = '0;
    bus.req_allowin = '0;
`ifdef ARB_LOCK_EN
    sel_last        = 1'b0;
`endif
    for (int unsigned i = 0; i < N; i++) begin
      if (winner == ID_W'(i)) begin
        sel_data           = bus.req_data[i*WIDTH +: WIDTH];
        bus.req_allowin[i] = grant;
`ifdef ARB_LOCK_EN
        sel_last           = bus.req_last[i];
`endif
      end
    end
  end

  // Output stage and arbitration history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      last_grant  <= ID_W'(N - 1);
`ifdef ARB_LOCK_EN
      locked      <= 1'b0;
      lock_id     <= '0;
`endif
    end else if (grant) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_id_q    <= winner;
      last_grant  <= winner;
`ifdef ARB_LOCK_EN
      // A beat without last (re)asserts the lock; a last beat releases it.
      locked      <= !sel_last;
      lock_id     <= winner;
`endif
    end else if (stage_allowin) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Self-checking bench for pipe_rr_arbiter (NREQ=4, WIDTH=32, ID_W=2).
// Directed scenarios followed by randomized traffic, compared against a
// cycle-level reference model of the arbitration rules.
module tb_pipe_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  pipe_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_valid   = 1'b0;
  logic [31:0] m_data    = '0;
  int          m_id      = 0;
  int          m_lg      = NREQ - 1;
  bit          m_locked  = 1'b0;
  int          m_lock_id = 0;

  logic [31:0] rd [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grant, clock, check output stage.
  task automatic step(input logic [3:0] v, input logic [3:0] last,
                      input logic oa, input logic rn);
    bit         stage;
    bit         has;
    int         w;
    logic [3:0] ea;
    bus.req_valid = v;
    bus.req_last  = last;
    bus.out_allow = oa;
    rst_n         = rn;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = rd[i];
    #1;
    stage = !m_valid || oa;
    has   = 1'b0;
    w     = 0;
    if (m_locked) begin
      w   = m_lock_id;
      has = v[w];
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_lg + k) % NREQ;
        if (!has && v[j]) begin
          has = 1'b1;
          w   = j;
        end
      end
    end
    ea = (rn && has && stage) ? 4'(1 << w) : 4'b0000;
    chk("req_allowin", 64'(bus.req_allowin), 64'(ea));
    @(posedge clk);
    if (!rn) begin
      m_valid  = 1'b0;
      m_data   = '0;
      m_id     = 0;
      m_lg     = NREQ - 1;
      m_locked = 1'b0;
    end else if (has && stage) begin
      m_valid = 1'b1;
      m_data  = rd[w];
      m_id    = w;
      m_lg    = w;
`ifdef ARB_LOCK_EN
      m_locked  = !last[w];
      m_lock_id = w;
`endif
    end else if (stage) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("out_data",  64'(bus.out_data),  64'(m_data));
    chk("out_id",    64'(bus.out_id),    64'(m_id));
    @(negedge clk);
  endtask

  initial begin
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.out_allow = 1'b0;
    for (int i = 0; i < NREQ; i++) rd[i] = 32'hA0 + 32'(i);
    @(negedge clk);

    // Reset state
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("reset_valid", 64'(bus.out_valid), 64'd0);

    // All requesters valid: strict rotation 0,1,2,3,0
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 4'b1111, 1'b1, 1'b1);
      chk("rotation_id", 64'(bus.out_id), 64'(exp_ids[c]));
      chk("rotation_data", 64'(bus.out_data), 64'(32'hA0 + 32'(exp_ids[c])));
    end

    // Single requester 2 streaming without bubbles
    for (int c = 0; c < 5; c++) begin
      rd[2] = 32'hB200 + 32'(c);
      step(4'b0100, 4'b1111, 1'b1, 1'b1);
      chk("single_id", 64'(bus.out_id), 64'd2);
      chk("single_valid", 64'(bus.out_valid), 64'd1);
    end

    // Stall with requesters 1 and 3 pending, then release: 3 goes first
    for (int c = 0; c < 3; c++) step(4'b1010, 4'b1111, 1'b0, 1'b1);
    chk("stall_hold_id", 64'(bus.out_id), 64'd2);
    step(4'b1010, 4'b1111, 1'b1, 1'b1);
    chk("after_stall_id", 64'(bus.out_id), 64'd3);

    // Reset during a stall with a valid beat held
    step(4'b1111, 4'b1111, 1'b0, 1'b0);
    chk("midstall_reset_valid", 64'(bus.out_valid), 64'd0);
    step(4'b1111, 4'b1111, 1'b1, 1'b1);
    chk("post_reset_first_id", 64'(bus.out_id), 64'd0);

    // Single requester toggling valid: bubble in the middle, data held
    rd[0] = 32'hC0C0_0001;
    step(4'b0001, 4'b1111, 1'b1, 1'b1);
    rd[0] = 32'hC0C0_0002;
    step(4'b0000, 4'b1111, 1'b1, 1'b1);
    chk("bubble_data_hold", 64'(bus.out_data), 64'h0000_0000_C0C0_0001);
    rd[0] = 32'hC0C0_0003;
    step(4'b0001, 4'b1111, 1'b1, 1'b1);

`ifdef ARB_LOCK_EN
    // Burst lock: requester 1 sends 3 beats while requester 0 stays valid
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0001, 4'b1111, 1'b1, 1'b1);
    step(4'b0011, 4'b0000, 1'b1, 1'b1);
    chk("lock_beat1", 64'(bus.out_id), 64'd1);
    step(4'b0011, 4'b0000, 1'b1, 1'b1);
    step(4'b0001, 4'b0000, 1'b1, 1'b1);
    step(4'b0001, 4'b0000, 1'b1, 1'b1);
    chk("lock_idle_noload", 64'(bus.out_valid), 64'd0);
    step(4'b0011, 4'b0010, 1'b1, 1'b1);
    chk("lock_beat3", 64'(bus.out_id), 64'd1);
    step(4'b0011, 4'b0000, 1'b1, 1'b1);
    chk("lock_released", 64'(bus.out_id), 64'd0);
`endif

    // Randomized traffic with occasional stalls and resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) rd[i] = $urandom;
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
- Shares one valid/allowin pipeline input among NREQ upstream requesters using round-robin arbitration.
- Grants at most one requester per cycle and captures the winning beat into a single output register stage.
- The output stage carries the beat data and the source ID.
- Sits in front of a stallable pipeline: out_valid/out_data drive the pipeline's validin/datain, and the pipeline's first-stage allowin drives out_allow.

Parameters:
- NREQ, 4, number of requesters, 2..16.
- WIDTH, 32, data width per requester.
- ID_W, 2, width of source ID; 2**ID_W >= NREQ is required.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  NREQ  per-requester valid, bit i = requester i
- req_data  input  NREQ*WIDTH  per-requester data, requester i at bits [i*WIDTH +: WIDTH]
- req_last  input  NREQ  last beat of burst; used only with ARB_LOCK_EN, ignored otherwise
- req_allowin  output  NREQ  one-hot or zero grant; a beat transfers when req_valid[i] && req_allowin[i]
- out_allow  input  1  downstream accepts the output beat
- out_valid  output  1  output stage holds a valid beat
- out_data  output  WIDTH  output beat data
- out_id  output  ID_W  index of the requester that supplied out_data

Behaviour:
- stage_allowin = !out_valid || out_allow (combinational).
- Priority order: last_grant+1, last_grant+2, ... wrapping modulo NREQ, then last_grant itself.
  - The winner is the first requester in that order with req_valid set.
- req_allowin[winner] = stage_allowin when a winner exists. All other bits are 0.
  - No bit of req_allowin is 1 while its req_valid is 0.
- On a transfer (any req_valid[i] && req_allowin[i]), at the next clk:
  - out_valid <= 1
  - out_data <= req_data[winner]
  - out_id <= winner
  - last_grant <= winner
- If stage_allowin is 1 and no requester is valid: out_valid <= 0; out_data, out_id and last_grant hold.
- If stage_allowin is 0: the output stage and last_grant hold, and all req_allowin bits are 0.
- Latency: one cycle from the accepted request to out_valid. Full throughput of 1 beat/cycle when out_allow is held at 1.
- Simultaneous drain and refill: out_valid=1 && out_allow=1 with a valid requester loads the new beat in the same cycle with no bubble.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... with no repeat within NREQ grants.
- Reset (any cycle, including mid-stall):
  - out_valid=0, out_data=0, out_id=0.
  - last_grant=NREQ-1, so requester 0 has top priority on the first arbitration.
  - Lock state cleared (lock feature).
  - req_allowin is 0 during reset.
- Requesters must hold req_valid/req_data stable until granted. The arbiter does not require this for correctness, but a beat is only consumed on the handshake.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: burst lock.
  - State: locked (1 bit) and lock_id (ID_W bits).
  - Transition: on a transfer from requester i with req_last[i]=0, locked <= 1 and lock_id <= i.
  - While locked, the winner is lock_id only. Its req_allowin = stage_allowin && req_valid[lock_id]. Other requesters are never granted, even if lock_id is idle.
  - Release: a transfer with req_last[lock_id]=1 sets locked <= 0 and last_grant <= lock_id. Round-robin resumes the next cycle.
  - Reset clears locked to 0.
- Undefined: req_last is ignored, no lock state exists, and every beat is arbitrated independently.

Test Plan:
- Reset then all 4 valid, data 0xA0..0xA3, out_allow=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles; out_data 0xA0,0xA1,...; out_valid=1 from cycle 2 onward.
- Only requester 2 valid, out_allow=1, 5 beats -> req_allowin=4'b0100 every cycle; 5 outputs with out_id=2 and no bubbles.
- Out_valid=1 with out_allow=0 for 3 cycles, requesters 1 and 3 valid -> req_allowin=0; out_data and out_id unchanged; on out_allow=1, the next beat is from requester 3 if last_grant=2.
- Rst_n=0 asserted for one cycle during a stall with out_valid=1 -> next cycle out_valid=0, out_id=0, req_allowin=0; the first grant after reset goes to requester 0 when all are valid.
- ARB_LOCK_EN: requester 1 sends 3 beats (req_last on the 3rd) while requester 0 is continuously valid -> out_id 1,1,1 and then 0. With requester 1 idle mid-burst for 2 cycles, no grants are issued during those cycles.
- Single requester toggling req_valid 1,0,1 with out_allow=1 -> out_valid 1,0,1 delayed by one cycle; out_data holds its value during the bubble.
